// File: rtl/lsu_dmem_ctrl.sv
// Load/store initiator driving the DMEM port for the memory stage; optional macro MISALIGN_SPLIT_EN splits misaligned half/word accesses into byte accesses.
// Latency from accept: aligned load 3 / store 2; split load 2N+1 / store N+1; illegal or rejected request 1.
// Backpressure: req_ready high only in IDLE, one request in flight; the response is a one-cycle pulse with no backpressure.
module lsu_dmem_ctrl #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_sign,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              dmem_rden,
    output logic              dmem_wen,
    output logic [1:0]        dmem_byte_sel,
    output logic              dmem_sign,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_din,
    input  logic [31:0]       dmem_dout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   we_q;
    logic   accept;
    logic   req_mis;
    logic   req_illegal;
    logic   last;

    // Next values of the registered outputs
    logic              nxt_ready;
    logic              nxt_rsp_valid;
    logic              nxt_rsp_err;
    logic [31:0]       nxt_rdata;
    logic              nxt_rden;
    logic              nxt_wen;
    logic [1:0]        nxt_bsel;
    logic              nxt_sign;
    logic [ADDR_W-1:0] nxt_addr;
    logic [31:0]       nxt_din;

    assign accept  = req_valid && req_ready;
    assign req_mis = ((req_size == 2'b01) && req_addr[0]) ||
                     ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

`ifdef MISALIGN_SPLIT_EN
    logic              split_q;
    logic [1:0]        size_q;
    logic              sign_q;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       wdata_q;
    logic [1:0]        cnt_q, cnt_d, cnt_inc;
    logic [23:0]       asm_q, asm_d;
    logic [31:0]       wshift;

    assign req_illegal = (req_size == 2'b11);
    assign cnt_inc     = cnt_q + 2'd1;
    // A split half ends after byte 1, a split word after byte 3
    assign last        = !split_q || (cnt_q == ((size_q == 2'b10) ? 2'd3 : 2'd1));
    assign wshift      = wdata_q >> {cnt_inc, 3'b000};
`else
    assign req_illegal = (req_size == 2'b11) || req_mis;
    assign last        = 1'b1;
`endif

    // State register and latched request direction
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q <= req_we;
            end
        end
    end

    // Next-state and next-output decode; DMEM address/data/size hold unless a strobe is issued
    always_comb begin
        state_d       = state_q;
        nxt_rsp_valid = 1'b0;
        nxt_rsp_err   = 1'b0;
        nxt_rdata     = '0;
        nxt_rden      = 1'b0;
        nxt_wen       = 1'b0;
        nxt_bsel      = dmem_byte_sel;
        nxt_sign      = dmem_sign;
        nxt_addr      = dmem_addr;
        nxt_din       = dmem_din;
`ifdef MISALIGN_SPLIT_EN
        cnt_d         = cnt_q;
        asm_d         = asm_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (req_illegal) begin
                        state_d       = S_RESP;
                        nxt_rsp_valid = 1'b1;
                        nxt_rsp_err   = 1'b1;
                    end else begin
                        state_d  = S_ISSUE;
                        nxt_rden = !req_we;
                        nxt_wen  = req_we;
                        nxt_bsel = req_size;
                        nxt_sign = req_sign;
                        nxt_addr = req_addr;
                        nxt_din  = req_wdata;
`ifdef MISALIGN_SPLIT_EN
                        cnt_d    = 2'd0;
                        asm_d    = '0;
                        if (req_mis) begin
                            nxt_bsel = 2'b00;
                            nxt_sign = 1'b0;
                            nxt_din  = {24'b0, req_wdata[7:0]};
                        end
`endif
                    end
                end
            end
            S_ISSUE: begin
                if (!we_q) begin
                    state_d = S_WAIT;
                end else if (last) begin
                    state_d       = S_RESP;
                    nxt_rsp_valid = 1'b1;
                end
`ifdef MISALIGN_SPLIT_EN
                else begin
                    nxt_wen  = 1'b1;
                    cnt_d    = cnt_inc;
                    nxt_addr = base_q + {{(ADDR_W-2){1'b0}}, cnt_inc};
                    nxt_din  = {24'b0, wshift[7:0]};
                end
`endif
            end
            S_WAIT: begin
                if (last) begin
                    state_d       = S_RESP;
                    nxt_rsp_valid = 1'b1;
                    nxt_rdata     = dmem_dout;
`ifdef MISALIGN_SPLIT_EN
                    if (split_q) begin
                        if (size_q == 2'b10) begin
                            nxt_rdata = {dmem_dout[7:0], asm_q};
                        end else begin
                            nxt_rdata = {{16{sign_q & dmem_dout[7]}}, dmem_dout[7:0], asm_q[7:0]};
                        end
                    end
`endif
                end
`ifdef MISALIGN_SPLIT_EN
                else begin
                    case (cnt_q)
                        2'd0:    asm_d[7:0]   = dmem_dout[7:0];
                        2'd1:    asm_d[15:8]  = dmem_dout[7:0];
                        default: asm_d[23:16] = dmem_dout[7:0];
                    endcase
                    state_d  = S_ISSUE;
                    nxt_rden = 1'b1;
                    cnt_d    = cnt_inc;
                    nxt_addr = base_q + {{(ADDR_W-2){1'b0}}, cnt_inc};
                end
`endif
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
        endcase
        nxt_ready = (state_d == S_IDLE);
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b0;
            dmem_rden     <= 1'b0;
            dmem_wen      <= 1'b0;
            dmem_byte_sel <= 2'b00;
            dmem_sign     <= 1'b0;
            dmem_addr     <= '0;
            dmem_din      <= '0;
        end else begin
            req_ready     <= nxt_ready;
            rsp_valid     <= nxt_rsp_valid;
            rsp_rdata     <= nxt_rdata;
            rsp_err       <= nxt_rsp_err;
            dmem_rden     <= nxt_rden;
            dmem_wen      <= nxt_wen;
            dmem_byte_sel <= nxt_bsel;
            dmem_sign     <= nxt_sign;
            dmem_addr     <= nxt_addr;
            dmem_din      <= nxt_din;
        end
    end

`ifdef MISALIGN_SPLIT_EN
    // Split bookkeeping: latched request fields, byte counter and load assembly buffer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            split_q <= 1'b0;
            size_q  <= 2'b00;
            sign_q  <= 1'b0;
            base_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= 2'd0;
            asm_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            asm_q <= asm_d;
            if (accept) begin
                split_q <= req_mis;
                size_q  <= req_size;
                sign_q  <= req_sign;
                base_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Testbench for lsu_dmem_ctrl: DMEM behavioural memory, strobe monitor and a byte-array reference model.
// Every request is timed from its accept edge and compared with latency/data/strobe expectations.
// Build with or without MISALIGN_SPLIT_EN; expectations follow the same macro.
module tb_lsu_dmem_ctrl;

`ifdef MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif
    localparam int AW    = 14;
    localparam int MEMSZ = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_sign;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          dmem_rden;
    logic          dmem_wen;
    logic [1:0]    dmem_byte_sel;
    logic          dmem_sign;
    logic [AW-1:0] dmem_addr;
    logic [31:0]   dmem_din;
    logic [31:0]   dmem_dout;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   din;
        logic [1:0]    bsel;
        logic          sign;
    } stb_t;
    stb_t stb_q[$];
    stb_t mon_s;
    int   both_hi = 0;

    logic [7:0] mem    [0:MEMSZ-1];
    logic [7:0] shadow [0:MEMSZ-1];
    bit         mem_cleared;
    logic [7:0] b0, b1, b2, b3;

    always #5 clk = ~clk;

    lsu_dmem_ctrl #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .dmem_rden(dmem_rden), .dmem_wen(dmem_wen), .dmem_byte_sel(dmem_byte_sel),
        .dmem_sign(dmem_sign), .dmem_addr(dmem_addr), .dmem_din(dmem_din), .dmem_dout(dmem_dout)
    );

    // DMEM: writes on the strobe edge, read data valid the cycle after the read strobe
    always @(posedge clk) begin
        if (!mem_cleared) begin
            for (int i = 0; i < MEMSZ; i++) mem[i] = 8'h00;
            mem_cleared = 1'b1;
        end
        if (dmem_wen) begin
            mem[dmem_addr] = dmem_din[7:0];
            if (dmem_byte_sel != 2'b00) mem[dmem_addr + 14'd1] = dmem_din[15:8];
            if (dmem_byte_sel == 2'b10) begin
                mem[dmem_addr + 14'd2] = dmem_din[23:16];
                mem[dmem_addr + 14'd3] = dmem_din[31:24];
            end
        end
        if (dmem_rden) begin
            b0 = mem[dmem_addr];
            b1 = mem[dmem_addr + 14'd1];
            b2 = mem[dmem_addr + 14'd2];
            b3 = mem[dmem_addr + 14'd3];
            case (dmem_byte_sel)
                2'b00:   dmem_dout <= {{24{dmem_sign & b0[7]}}, b0};
                2'b01:   dmem_dout <= {{16{dmem_sign & b1[7]}}, b1, b0};
                default: dmem_dout <= {b3, b2, b1, b0};
            endcase
        end
    end

    // Strobe monitor
    always @(negedge clk) begin
        if (dmem_rden || dmem_wen) begin
            mon_s.we   = dmem_wen;
            mon_s.addr = dmem_addr;
            mon_s.din  = dmem_din;
            mon_s.bsel = dmem_byte_sel;
            mon_s.sign = dmem_sign;
            stb_q.push_back(mon_s);
        end
        if (dmem_rden && dmem_wen) both_hi++;
    end

    // ---------------- reference model ----------------
    function automatic bit m_mis(input logic [1:0] size, input logic [AW-1:0] addr);
        return (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
    endfunction

    function automatic bit m_err(input logic [1:0] size, input logic [AW-1:0] addr);
        return (size == 2'd3) || (!SPLIT && m_mis(size, addr));
    endfunction

    function automatic int m_nacc(input logic [1:0] size, input logic [AW-1:0] addr);
        if (m_err(size, addr)) return 0;
        if (!m_mis(size, addr)) return 1;
        return (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic int m_lat(input bit we, input logic [1:0] size, input logic [AW-1:0] addr);
        int n;
        n = m_nacc(size, addr);
        if (n == 0) return 1;
        if (!m_mis(size, addr)) return we ? 2 : 3;
        return we ? n + 1 : 2 * n + 1;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] size, input bit sign, input logic [AW-1:0] addr);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < (1 << size); i++)
            v = v | (32'(shadow[14'(int'(addr) + i)]) << (8 * i));
        if (sign && size == 2'd0) v = {{24{v[7]}}, v[7:0]};
        if (sign && size == 2'd1) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic model_store(input logic [1:0] size, input logic [AW-1:0] addr, input logic [31:0] wdata);
        for (int i = 0; i < (1 << size); i++)
            shadow[14'(int'(addr) + i)] = 8'(wdata >> (8 * i));
    endtask

    // Drives one request, keeps junk on the request bus while busy, and reports what it observed
    task automatic run_req(input bit we, input logic [1:0] size, input bit sign,
                           input logic [AW-1:0] addr, input logic [31:0] wdata,
                           output int lat, output logic [31:0] rdata, output logic err,
                           output logic rdy_rsp, output logic rdy_after, output logic vld_after);
        int guard;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        stb_q.delete();
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_sign  = sign;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        req_we    = 1'($urandom);
        req_size  = 2'($urandom);
        req_sign  = 1'($urandom);
        req_addr  = 14'($urandom);
        req_wdata = $urandom;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (rsp_valid !== 1'b1 && lat < 40);
        if (rsp_valid !== 1'b1) lat = -1;
        rdata     = rsp_rdata;
        err       = rsp_err;
        rdy_rsp   = req_ready;
        req_valid = 1'b0;
        @(negedge clk);
        rdy_after = req_ready;
        vld_after = rsp_valid;
        if (we && !m_err(size, addr)) model_store(size, addr, wdata);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_size  = 2'b00;
        req_sign  = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < MEMSZ; i++) shadow[i] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready got=%b exp=1", req_ready);
        end
        checks++;
        if ({rsp_valid, rsp_err, dmem_rden, dmem_wen, dmem_sign} !== 5'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=00000", {rsp_valid, rsp_err, dmem_rden, dmem_wen, dmem_sign});
        end
        checks++;
        if (rsp_rdata !== 32'h0 || dmem_din !== 32'h0 || dmem_addr !== 14'h0 || dmem_byte_sel !== 2'b00) begin
            failures++; $display("FAIL reset_data rdata=%h din=%h addr=%h bsel=%b exp all zero", rsp_rdata, dmem_din, dmem_addr, dmem_byte_sel);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_aligned();
        int lat; logic [31:0] rd; logic er, r1, r2, v2;
        run_req(1'b1, 2'b10, 1'b0, 14'h0, 32'hDEADBEE0, lat, rd, er, r1, r2, v2);
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL al_st_lat got=%0d exp=2", lat); end
        checks++;
        if (er !== 1'b0 || rd !== 32'h0) begin failures++; $display("FAIL al_st_rsp err=%b rdata=%h exp err=0 rdata=0", er, rd); end
        checks++;
        if (stb_q.size() != 1 || stb_q[0].we !== 1'b1 || stb_q[0].addr !== 14'h0 ||
            stb_q[0].din !== 32'hDEADBEE0 || stb_q[0].bsel !== 2'b10) begin
            failures++; $display("FAIL al_st_strobe count=%0d exp one word write @0", stb_q.size());
        end
        run_req(1'b0, 2'b10, 1'b0, 14'h0, 32'h0, lat, rd, er, r1, r2, v2);
        checks++;
        if (lat !== 3) begin failures++; $display("FAIL al_ld_lat got=%0d exp=3", lat); end
        checks++;
        if (rd !== 32'hDEADBEE0 || er !== 1'b0) begin failures++; $display("FAIL al_ld_data got=%h err=%b exp=deadbee0 err=0", rd, er); end
        checks++;
        if (stb_q.size() != 1 || stb_q[0].we !== 1'b0 || stb_q[0].bsel !== 2'b10) begin
            failures++; $display("FAIL al_ld_strobe count=%0d exp one word read", stb_q.size());
        end
    endtask

    task automatic test_byte_sign();
        int lat; logic [31:0] rd; logic er, r1, r2, v2;
        run_req(1'b1, 2'b00, 1'b0, 14'h8, 32'h5A5A5AE8, lat, rd, er, r1, r2, v2);
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL byte_st_lat got=%0d exp=2", lat); end
        run_req(1'b0, 2'b00, 1'b1, 14'h8, 32'h0, lat, rd, er, r1, r2, v2);
        checks++;
        if (stb_q.size() != 1 || stb_q[0].bsel !== 2'b00 || stb_q[0].sign !== 1'b1 || stb_q[0].addr !== 14'h8) begin
            failures++; $display("FAIL byte_ld_strobe count=%0d exp bsel=00 sign=1 addr=8", stb_q.size());
        end
        checks++;
        if (rd !== 32'hFFFFFFE8 || lat !== 3) begin failures++; $display("FAIL byte_ld_sext got=%h lat=%0d exp=ffffffe8 lat=3", rd, lat); end
        run_req(1'b0, 2'b00, 1'b0, 14'h8, 32'h0, lat, rd, er, r1, r2, v2);
        checks++;
        if (rd !== 32'h000000E8) begin failures++; $display("FAIL byte_ld_zext got=%h exp=000000e8", rd); end
    endtask

    task automatic test_misaligned();
        int lat; logic [31:0] rd; logic er, r1, r2, v2;
        logic [7:0] eb [4];
        eb[0] = 8'hEF; eb[1] = 8'hBE; eb[2] = 8'hAD; eb[3] = 8'hDE;
`ifdef MISALIGN_SPLIT_EN
        run_req(1'b1, 2'b10, 1'b0, 14'h1, 32'hDEADBEEF, lat, rd, er, r1, r2, v2);
        checks++;
        if (lat !== 5 || er !== 1'b0) begin failures++; $display("FAIL split_st_lat got=%0d err=%b exp=5 err=0", lat, er); end
        checks++;
        if (stb_q.size() != 4) begin
            failures++; $display("FAIL split_st_count got=%0d exp=4", stb_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (stb_q[k].we !== 1'b1 || stb_q[k].addr !== 14'(1 + k) || stb_q[k].din !== {24'h0, eb[k]} ||
                    stb_q[k].bsel !== 2'b00 || stb_q[k].sign !== 1'b0) begin
                    failures++; $display("FAIL split_st_byte k=%0d addr=%h din=%h exp addr=%h din=%h", k, stb_q[k].addr, stb_q[k].din, 1 + k, eb[k]);
                end
            end
        end
        run_req(1'b0, 2'b10, 1'b0, 14'h1, 32'h0, lat, rd, er, r1, r2, v2);
        checks++;
        if (lat !== 9 || rd !== 32'hDEADBEEF) begin failures++; $display("FAIL split_ld_word lat=%0d data=%h exp lat=9 data=deadbeef", lat, rd); end
        run_req(1'b1, 2'b00, 1'b0, 14'h3FFF, 32'h80, lat, rd, er, r1, r2, v2);
        run_req(1'b1, 2'b00, 1'b0, 14'h0000, 32'h12, lat, rd, er, r1, r2, v2);
        run_req(1'b0, 2'b01, 1'b1, 14'h3FFF, 32'h0, lat, rd, er, r1, r2, v2);
        checks++;
        if (stb_q.size() != 2 || stb_q[0].addr !== 14'h3FFF || stb_q[1].addr !== 14'h0000) begin
            failures++; $display("FAIL split_wrap_addr count=%0d exp 3fff then 0000", stb_q.size());
        end
        checks++;
        if (rd !== 32'h00001280 || lat !== 5) begin failures++; $display("FAIL split_wrap_data got=%h lat=%0d exp=00001280 lat=5", rd, lat); end
        run_req(1'b0, 2'b11, 1'b0, 14'h4, 32'h0, lat, rd, er, r1, r2, v2);
        checks++;
        if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || stb_q.size() != 0) begin
            failures++; $display("FAIL illegal_size lat=%0d err=%b rdata=%h strobes=%0d exp 1/1/0/0", lat, er, rd, stb_q.size());
        end
`else
        run_req(1'b1, 2'b10, 1'b0, 14'h1, 32'hDEADBEEF, lat, rd, er, r1, r2, v2);
        checks++;
        if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || stb_q.size() != 0) begin
            failures++; $display("FAIL mis_st_reject lat=%0d err=%b rdata=%h strobes=%0d exp 1/1/0/0", lat, er, rd, stb_q.size());
        end
        checks++;
        if (mem[1] !== 8'hBE) begin failures++; $display("FAIL mis_st_nowrite mem1=%h exp=be", mem[1]); end
        run_req(1'b0, 2'b01, 1'b1, 14'h3FFF, 32'h0, lat, rd, er, r1, r2, v2);
        checks++;
        if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || stb_q.size() != 0) begin
            failures++; $display("FAIL mis_ld_reject lat=%0d err=%b rdata=%h strobes=%0d exp 1/1/0/0", lat, er, rd, stb_q.size());
        end
        run_req(1'b1, 2'b11, 1'b0, 14'h4, 32'h0, lat, rd, er, r1, r2, v2);
        checks++;
        if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || stb_q.size() != 0) begin
            failures++; $display("FAIL illegal_size lat=%0d err=%b rdata=%h strobes=%0d exp 1/1/0/0", lat, er, rd, stb_q.size());
        end
        checks++;
        if (eb[0] !== 8'hEF) begin failures++; $display("FAIL tb_table got=%h exp=ef", eb[0]); end
`endif
    endtask

    task automatic test_reset_midop();
        int lat, seen; logic [31:0] rd; logic er, r1, r2, v2;
        seen = 0;
        req_valid = 1'b1;
        req_sign  = 1'b0;
        req_size  = 2'b10;
`ifdef MISALIGN_SPLIT_EN
        req_we    = 1'b1;
        req_addr  = 14'h101;
        req_wdata = 32'h11223344;
`else
        req_we    = 1'b0;
        req_addr  = 14'h100;
        req_wdata = 32'h0;
`endif
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ((dmem_wen | dmem_rden) !== 1'b1 || dmem_addr !== req_addr) begin
            failures++; $display("FAIL midop_issue0 wen=%b rden=%b addr=%h exp strobe @%h", dmem_wen, dmem_rden, dmem_addr, req_addr);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({dmem_rden, dmem_wen, rsp_valid} !== 3'b000 || req_ready !== 1'b1) begin
            failures++; $display("FAIL midop_abort rden=%b wen=%b rsp=%b ready=%b exp 0/0/0/1", dmem_rden, dmem_wen, rsp_valid, req_ready);
        end
        checks++;
        if (dmem_addr !== 14'h0 || dmem_din !== 32'h0) begin
            failures++; $display("FAIL midop_bus addr=%h din=%h exp 0", dmem_addr, dmem_din);
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid === 1'b1 || dmem_wen === 1'b1 || dmem_rden === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL midop_quiet activity=%0d exp=0", seen); end
`ifdef MISALIGN_SPLIT_EN
        checks++;
        if (mem[14'h101] !== 8'h44 || mem[14'h102] !== 8'h00 || mem[14'h103] !== 8'h00 || mem[14'h104] !== 8'h00) begin
            failures++; $display("FAIL midop_partial bytes=%h %h %h %h exp 44 00 00 00", mem[14'h101], mem[14'h102], mem[14'h103], mem[14'h104]);
        end
        shadow[14'h101] = 8'h44;
        run_req(1'b0, 2'b00, 1'b0, 14'h101, 32'h0, lat, rd, er, r1, r2, v2);
        checks++;
        if (rd !== 32'h44 || lat !== 3) begin failures++; $display("FAIL midop_after got=%h lat=%0d exp=00000044 lat=3", rd, lat); end
`else
        run_req(1'b0, 2'b10, 1'b0, 14'h100, 32'h0, lat, rd, er, r1, r2, v2);
        checks++;
        if (rd !== 32'h0 || lat !== 3) begin failures++; $display("FAIL midop_after got=%h lat=%0d exp=0 lat=3", rd, lat); end
`endif
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] rd; logic er, r1, r2, v2;
        run_req(1'b1, 2'b01, 1'b0, 14'h40, 32'h0000C3A5, lat, rd, er, r1, r2, v2);
        checks++;
        if (r1 !== 1'b0 || r2 !== 1'b1 || v2 !== 1'b0) begin
            failures++; $display("FAIL b2b_ready_st rdy_in_rsp=%b rdy_after=%b rsp_after=%b exp 0/1/0", r1, r2, v2);
        end
        run_req(1'b0, 2'b01, 1'b1, 14'h40, 32'h0, lat, rd, er, r1, r2, v2);
        checks++;
        if (rd !== 32'hFFFFC3A5 || lat !== 3) begin failures++; $display("FAIL b2b_load got=%h lat=%0d exp=ffffc3a5 lat=3", rd, lat); end
        checks++;
        if (r1 !== 1'b0 || r2 !== 1'b1 || v2 !== 1'b0) begin
            failures++; $display("FAIL b2b_ready_ld rdy_in_rsp=%b rdy_after=%b rsp_after=%b exp 0/1/0", r1, r2, v2);
        end
    endtask

    task automatic test_random();
        int lat, n, elat; logic [31:0] rd, erd, edin; logic er, r1, r2, v2;
        bit we, sign, mis, eer; logic [1:0] size, ebsel; logic [AW-1:0] addr, eaddr; logic [31:0] wd;
        logic esign;
        for (int i = 0; i < 200; i++) begin
            int r;
            we   = 1'($urandom);
            sign = 1'($urandom);
            wd   = $urandom;
            r    = int'($urandom_range(0, 9));
            size = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            addr = ($urandom_range(0, 1) == 0) ? 14'($urandom_range(0, 31)) : 14'(32'h3FF0 + $urandom_range(0, 15));
            eer  = m_err(size, addr);
            mis  = m_mis(size, addr);
            n    = m_nacc(size, addr);
            elat = m_lat(we, size, addr);
            erd  = (we || eer) ? 32'h0 : m_load(size, sign, addr);
            run_req(we, size, sign, addr, wd, lat, rd, er, r1, r2, v2);
            checks++;
            if (lat !== elat) begin failures++; $display("FAIL rnd_lat i=%0d got=%0d exp=%0d", i, lat, elat); end
            checks++;
            if (er !== eer || rd !== erd) begin
                failures++; $display("FAIL rnd_rsp i=%0d we=%b size=%0d addr=%h err=%b rdata=%h exp err=%b rdata=%h", i, we, size, addr, er, rd, eer, erd);
            end
            checks++;
            if (r1 !== 1'b0 || r2 !== 1'b1 || v2 !== 1'b0) begin
                failures++; $display("FAIL rnd_hs i=%0d rdy_in_rsp=%b rdy_after=%b rsp_after=%b exp 0/1/0", i, r1, r2, v2);
            end
            checks++;
            if (stb_q.size() != n) begin
                failures++; $display("FAIL rnd_nstb i=%0d got=%0d exp=%0d", i, stb_q.size(), n);
            end else begin
                for (int k = 0; k < n; k++) begin
                    eaddr = mis ? 14'(int'(addr) + k) : addr;
                    ebsel = mis ? 2'b00 : size;
                    esign = mis ? 1'b0 : sign;
                    edin  = mis ? {24'h0, 8'(wd >> (8 * k))} : wd;
                    checks++;
                    if (stb_q[k].we !== we || stb_q[k].addr !== eaddr || stb_q[k].bsel !== ebsel ||
                        stb_q[k].sign !== esign || (we && stb_q[k].din !== edin)) begin
                        failures++; $display("FAIL rnd_stb i=%0d k=%0d we=%b addr=%h bsel=%b sign=%b din=%h exp we=%b addr=%h bsel=%b sign=%b din=%h",
                                             i, k, stb_q[k].we, stb_q[k].addr, stb_q[k].bsel, stb_q[k].sign, stb_q[k].din,
                                             we, eaddr, ebsel, esign, edin);
                    end
                end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_aligned();
        test_byte_sign();
        test_misaligned();
        test_reset_midop();
        test_back_to_back();
        test_random();
        checks++;
        if (both_hi != 0) begin failures++; $display("FAIL rden_wen_together got=%0d exp=0", both_hi); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
